mem_port_arbiter: RTL and testbench

//  Shares one 16 kB synchronous byte-array memory (1-cycle registered read, rb/wb/adrb/din/dout port)

---
 rtl/mem_port_arbiter_pkg.sv | 27 ++
 rtl/mem_port_arbiter_if.sv | 41 ++++
 rtl/mem_port_arbiter_prio.sv | 42 ++++
 rtl/mem_port_arbiter.sv | 127 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the two-port memory arbiter.
package mem_arb_pkg;

    localparam int unsigned ADDR_W           = 15;
    localparam int unsigned DATA_W           = 16;
    localparam int unsigned MEM_BYTES        = 16384;
    localparam int unsigned STARVE_LIMIT_DEF = 4;

    // A two-byte access starting at the last byte would run past the array.
    localparam logic [ADDR_W-1:0] ADDR_MAX = ADDR_W'(MEM_BYTES - 2);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_e;

    typedef enum logic {
        OWN_A = 1'b0,
        OWN_B = 1'b1
    } owner_e;

    function automatic logic addr_in_range(input logic [ADDR_W-1:0] addr);
        return (addr <= ADDR_MAX);
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Client ports A/B plus the memory strobe port; master = pipeline/memory side, slave = arbiter.
interface mem_port_arbiter_if
    import mem_arb_pkg::*;
();
    logic              a_req;
    logic [ADDR_W-1:0] a_addr;
    logic              a_gnt;
    logic              a_rvalid;
    logic [DATA_W-1:0] a_rdata;
    logic              a_err;

    logic              b_req;
    logic              b_we;
    logic [ADDR_W-1:0] b_addr;
    logic [DATA_W-1:0] b_wdata;
    logic              b_gnt;
    logic              b_rvalid;
    logic [DATA_W-1:0] b_rdata;
    logic              b_err;

    logic              mem_rb;
    logic              mem_wb;
    logic [ADDR_W-1:0] mem_adrb;
    logic [DATA_W-1:0] mem_din;
    logic [DATA_W-1:0] mem_dout;

    modport slave (
        input  a_req, a_addr, b_req, b_we, b_addr, b_wdata, mem_dout,
        output a_gnt, a_rvalid, a_rdata, a_err,
        output b_gnt, b_rvalid, b_rdata, b_err,
        output mem_rb, mem_wb, mem_adrb, mem_din
    );

    modport master (
        output a_req, a_addr, b_req, b_we, b_addr, b_wdata, mem_dout,
        input  a_gnt, a_rvalid, a_rdata, a_err,
        input  b_gnt, b_rvalid, b_rdata, b_err,
        input  mem_rb, mem_wb, mem_adrb, mem_din
    );

endinterface

// File: rtl/mem_port_arbiter_prio.sv
// Two-way priority pick (B preferred) with a saturating starvation counter for A.
module mem_arb_prio #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en_i,
    input  logic a_req_i,
    input  logic b_req_i,
    output logic a_win_o,
    output logic b_win_o
);

    localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] starve_q;
    logic             starved_s;

    // Winner selection: B wins ties unless A has been starved long enough.
    always_comb begin
        starved_s = (starve_q == CNT_MAX);
        a_win_o   = a_req_i && (!b_req_i || starved_s);
        b_win_o   = b_req_i && !a_win_o;
    end

    // Counts arbitration slots that A requested but lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_q <= {CNT_W{1'b0}};
        end else if (!a_req_i) begin
            starve_q <= {CNT_W{1'b0}};
        end else if (en_i && a_win_o) begin
            starve_q <= {CNT_W{1'b0}};
        end else if (en_i && b_win_o && !starved_s) begin
            starve_q <= starve_q + CNT_W'(1);
        end else begin
            starve_q <= starve_q;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one registered-read byte memory between a fetch port (A) and a load/store port (B).
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    mem_port_arbiter_if.slave bus
);

    state_e            state_q;
    owner_e            owner_q;
    logic              err_q;
    logic              rvalid_q;
    logic              mem_rb_q;
    logic              mem_wb_q;
    logic [ADDR_W-1:0] mem_adrb_q;
    logic [DATA_W-1:0] mem_din_q;

    logic              can_grant_s;
    logic              a_win_s;
    logic              b_win_s;
    logic              any_gnt_s;
    logic              sel_we_s;
    logic              sel_ok_s;
    logic [ADDR_W-1:0] sel_addr_s;
    logic              own_a_s;
    logic              own_b_s;

    mem_arb_prio #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_prio (
        .clk     (clk),
        .rst_n   (rst_n),
        .en_i    (can_grant_s),
        .a_req_i (bus.a_req),
        .a_win_o (a_win_s),
        .b_req_i (bus.b_req),
        .b_win_o (b_win_s)
    );

    // Grant slot and the winner's request fields.
    always_comb begin
        can_grant_s = (state_q == IDLE) || (state_q == RESP);
        any_gnt_s   = can_grant_s && (a_win_s || b_win_s);
        if (b_win_s) begin
            sel_addr_s = bus.b_addr;
            sel_we_s   = bus.b_we;
        end else begin
            sel_addr_s = bus.a_addr;
            sel_we_s   = 1'b0;
        end
        sel_ok_s = addr_in_range(sel_addr_s);
    end

    // Sequencer: IDLE/RESP accept a grant, ISSUE drives one strobe, RESP returns data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            owner_q    <= OWN_A;
            err_q      <= 1'b0;
            rvalid_q   <= 1'b0;
            mem_rb_q   <= 1'b0;
            mem_wb_q   <= 1'b0;
            mem_adrb_q <= {ADDR_W{1'b0}};
            mem_din_q  <= {DATA_W{1'b0}};
        end else begin
            mem_rb_q <= 1'b0;
            mem_wb_q <= 1'b0;
            rvalid_q <= 1'b0;
            case (state_q)
                IDLE, RESP: begin
                    if (any_gnt_s) begin
                        owner_q    <= b_win_s ? OWN_B : OWN_A;
                        err_q      <= !sel_ok_s;
                        mem_adrb_q <= sel_addr_s;
                        if (b_win_s && bus.b_we) begin
                            mem_din_q <= bus.b_wdata;
                        end else begin
                            mem_din_q <= mem_din_q;
                        end
                        if (sel_ok_s) begin
                            mem_rb_q <= !sel_we_s;
                            mem_wb_q <= sel_we_s;
                            state_q  <= ISSUE;
                        end else begin
                            // Out-of-range ops skip the memory and answer next cycle.
                            rvalid_q <= 1'b1;
                            state_q  <= RESP;
                        end
                    end else begin
                        state_q <= IDLE;
                    end
                end
                ISSUE: begin
                    if (mem_wb_q) begin
                        state_q <= IDLE;
                    end else begin
                        rvalid_q <= 1'b1;
                        state_q  <= RESP;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign own_a_s = rvalid_q && (owner_q == OWN_A);
    assign own_b_s = rvalid_q && (owner_q == OWN_B);

    assign bus.a_gnt    = can_grant_s && a_win_s;
    assign bus.b_gnt    = can_grant_s && b_win_s;
    assign bus.a_rvalid = own_a_s;
    assign bus.b_rvalid = own_b_s;
    assign bus.a_err    = own_a_s && err_q;
    assign bus.b_err    = own_b_s && err_q;
    assign bus.a_rdata  = (own_a_s && !err_q) ? bus.mem_dout : {DATA_W{1'b0}};
    assign bus.b_rdata  = (own_b_s && !err_q) ? bus.mem_dout : {DATA_W{1'b0}};
    assign bus.mem_rb   = mem_rb_q;
    assign bus.mem_wb   = mem_wb_q;
    assign bus.mem_adrb = mem_adrb_q;
    assign bus.mem_din  = mem_din_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a little-endian byte-array memory model.
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   strobe_cnt = 0;
    int   both_cnt = 0;
    int   s0;
    int   ng;
    logic [1:0] exp_g;
    logic [7:0] mem [0:MEM_BYTES-1];

    mem_port_arbiter_if bus_if ();

    mem_port_arbiter #(
        .STARVE_LIMIT (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;

    // Memory model: registered read, byte at adrb is the low half.
    always @(posedge clk) begin
        if (bus_if.mem_rb) begin
            bus_if.mem_dout <= {mem[int'(bus_if.mem_adrb) + 1], mem[int'(bus_if.mem_adrb)]};
        end
        if (bus_if.mem_wb) begin
            mem[int'(bus_if.mem_adrb)]     <= bus_if.mem_din[7:0];
            mem[int'(bus_if.mem_adrb) + 1] <= bus_if.mem_din[15:8];
        end
        if (bus_if.mem_rb || bus_if.mem_wb) strobe_cnt <= strobe_cnt + 1;
        if (bus_if.mem_rb && bus_if.mem_wb) both_cnt <= both_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus_if.a_req   = 1'b0;
        bus_if.a_addr  = 15'h0000;
        bus_if.b_req   = 1'b0;
        bus_if.b_we    = 1'b0;
        bus_if.b_addr  = 15'h0000;
        bus_if.b_wdata = 16'h0000;
        for (int i = 0; i < MEM_BYTES; i++) mem[i] <= 8'h00;
        #1;
        mem[32'h10]   <= 8'h34;
        mem[32'h11]   <= 8'h12;
        mem[32'h0]    <= 8'h01;
        mem[32'h1]    <= 8'h02;
        mem[32'h2]    <= 8'h03;
        mem[32'h3]    <= 8'h04;
        mem[32'h4]    <= 8'h05;
        mem[32'h5]    <= 8'h06;
        mem[32'h3FFE] <= 8'h78;
        mem[32'h3FFF] <= 8'h56;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        check("rst_a_gnt",    32'(bus_if.a_gnt),    32'd0);
        check("rst_a_rvalid", 32'(bus_if.a_rvalid), 32'd0);
        check("rst_a_err",    32'(bus_if.a_err),    32'd0);
        check("rst_a_rdata",  32'(bus_if.a_rdata),  32'd0);
        check("rst_b_rvalid", 32'(bus_if.b_rvalid), 32'd0);
        check("rst_b_rdata",  32'(bus_if.b_rdata),  32'd0);
        check("rst_mem_rb",   32'(bus_if.mem_rb),   32'd0);
        check("rst_mem_wb",   32'(bus_if.mem_wb),   32'd0);
        check("rst_mem_adrb", 32'(bus_if.mem_adrb), 32'd0);
        check("rst_mem_din",  32'(bus_if.mem_din),  32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // 1: single A read
        @(negedge clk);
        bus_if.a_req = 1'b1; bus_if.a_addr = 15'h0010;
        #1;
        check("t1_a_gnt", 32'(bus_if.a_gnt), 32'd1);
        check("t1_b_gnt", 32'(bus_if.b_gnt), 32'd0);
        @(negedge clk);
        bus_if.a_req = 1'b0;
        #1;
        check("t1_mem_rb",   32'(bus_if.mem_rb),   32'd1);
        check("t1_mem_wb",   32'(bus_if.mem_wb),   32'd0);
        check("t1_mem_adrb", 32'(bus_if.mem_adrb), 32'h10);
        check("t1_rv_early", 32'(bus_if.a_rvalid), 32'd0);
        @(negedge clk); #1;
        check("t1_a_rvalid", 32'(bus_if.a_rvalid), 32'd1);
        check("t1_a_rdata",  32'(bus_if.a_rdata),  32'h1234);
        check("t1_a_err",    32'(bus_if.a_err),    32'd0);
        check("t1_b_rvalid", 32'(bus_if.b_rvalid), 32'd0);
        check("t1_b_rdata",  32'(bus_if.b_rdata),  32'd0);
        check("t1_rb_off",   32'(bus_if.mem_rb),   32'd0);
        @(negedge clk); #1;
        check("t1_rv_pulse", 32'(bus_if.a_rvalid), 32'd0);

        // 2: B write then B read back
        @(negedge clk);
        bus_if.b_req = 1'b1; bus_if.b_we = 1'b1; bus_if.b_addr = 15'h0020; bus_if.b_wdata = 16'hBEEF;
        #1;
        check("t2_b_gnt", 32'(bus_if.b_gnt), 32'd1);
        @(negedge clk);
        bus_if.b_req = 1'b0; bus_if.b_we = 1'b0;
        #1;
        check("t2_mem_wb",   32'(bus_if.mem_wb),   32'd1);
        check("t2_mem_rb",   32'(bus_if.mem_rb),   32'd0);
        check("t2_mem_din",  32'(bus_if.mem_din),  32'hBEEF);
        check("t2_mem_adrb", 32'(bus_if.mem_adrb), 32'h20);
        @(negedge clk);
        bus_if.b_req = 1'b1; bus_if.b_we = 1'b0; bus_if.b_addr = 15'h0020;
        #1;
        check("t2_no_wr_rvalid", 32'(bus_if.b_rvalid), 32'd0);
        check("t2_wb_off",       32'(bus_if.mem_wb),   32'd0);
        check("t2_rd_gnt",       32'(bus_if.b_gnt),    32'd1);
        @(negedge clk);
        bus_if.b_req = 1'b0;
        @(negedge clk); #1;
        check("t2_b_rvalid", 32'(bus_if.b_rvalid), 32'd1);
        check("t2_b_rdata",  32'(bus_if.b_rdata),  32'hBEEF);
        check("t2_a_rdata",  32'(bus_if.a_rdata),  32'd0);
        @(negedge clk);

        // 3: both ports hammering, starvation guard
        bus_if.a_req = 1'b1; bus_if.a_addr = 15'h0010;
        bus_if.b_req = 1'b1; bus_if.b_we = 1'b0; bus_if.b_addr = 15'h0020;
        ng = 0;
        for (int cyc = 0; cyc < 40 && ng < 10; cyc++) begin
            if (cyc > 0) @(negedge clk);
            #1;
            if (bus_if.a_gnt || bus_if.b_gnt) begin
                exp_g = ((ng % 5) == 4) ? 2'b10 : 2'b01;
                check("t3_grant", 32'({bus_if.a_gnt, bus_if.b_gnt}), 32'(exp_g));
                ng++;
            end
        end
        check("t3_grant_count", 32'(ng), 32'd10);
        bus_if.a_req = 1'b0; bus_if.b_req = 1'b0;
        repeat (3) @(negedge clk);

        // 4: out-of-range read and write, plus last legal address
        s0 = strobe_cnt;
        bus_if.b_req = 1'b1; bus_if.b_we = 1'b0; bus_if.b_addr = 15'h3FFF;
        #1;
        check("t4_b_gnt", 32'(bus_if.b_gnt), 32'd1);
        @(negedge clk);
        bus_if.b_req = 1'b0;
        #1;
        check("t4_b_rvalid", 32'(bus_if.b_rvalid), 32'd1);
        check("t4_b_err",    32'(bus_if.b_err),    32'd1);
        check("t4_b_rdata",  32'(bus_if.b_rdata),  32'd0);
        check("t4_a_err",    32'(bus_if.a_err),    32'd0);
        @(negedge clk);
        bus_if.b_req = 1'b1; bus_if.b_we = 1'b1; bus_if.b_addr = 15'h3FFF; bus_if.b_wdata = 16'hAAAA;
        #1;
        check("t4_wr_gnt", 32'(bus_if.b_gnt), 32'd1);
        @(negedge clk);
        bus_if.b_req = 1'b0; bus_if.b_we = 1'b0;
        #1;
        check("t4_wr_rvalid", 32'(bus_if.b_rvalid), 32'd1);
        check("t4_wr_err",    32'(bus_if.b_err),    32'd1);
        repeat (2) @(negedge clk);
        #1;
        check("t4_no_strobe", 32'(strobe_cnt - s0), 32'd0);
        check("t4_mem_kept",  32'(mem[32'h3FFF]),   32'h56);
        bus_if.b_req = 1'b1; bus_if.b_addr = 15'h3FFE;
        #1;
        check("t4_edge_gnt", 32'(bus_if.b_gnt), 32'd1);
        @(negedge clk);
        bus_if.b_req = 1'b0;
        @(negedge clk); #1;
        check("t4_edge_err",   32'(bus_if.b_err),   32'd0);
        check("t4_edge_rdata", 32'(bus_if.b_rdata), 32'h5678);
        @(negedge clk);

        // 5: back-to-back A reads
        bus_if.a_req = 1'b1; bus_if.a_addr = 15'h0000;
        #1;
        check("t5_gnt_c0", 32'(bus_if.a_gnt), 32'd1);
        @(negedge clk);
        bus_if.a_addr = 15'h0002;
        #1;
        check("t5_gnt_c1", 32'(bus_if.a_gnt),    32'd0);
        check("t5_adr_c1", 32'(bus_if.mem_adrb), 32'h0);
        @(negedge clk); #1;
        check("t5_gnt_c2", 32'(bus_if.a_gnt),    32'd1);
        check("t5_rv_c2",  32'(bus_if.a_rvalid), 32'd1);
        check("t5_dat_c2", 32'(bus_if.a_rdata),  32'h0201);
        @(negedge clk);
        bus_if.a_addr = 15'h0004;
        #1;
        check("t5_rv_c3",  32'(bus_if.a_rvalid), 32'd0);
        check("t5_adr_c3", 32'(bus_if.mem_adrb), 32'h2);
        @(negedge clk); #1;
        check("t5_gnt_c4", 32'(bus_if.a_gnt),    32'd1);
        check("t5_dat_c4", 32'(bus_if.a_rdata),  32'h0403);
        @(negedge clk);
        bus_if.a_req = 1'b0;
        #1;
        check("t5_rv_c5",  32'(bus_if.a_rvalid), 32'd0);
        @(negedge clk); #1;
        check("t5_rv_c6",  32'(bus_if.a_rvalid), 32'd1);
        check("t5_dat_c6", 32'(bus_if.a_rdata),  32'h0605);
        @(negedge clk);

        // 6: reset during ISSUE of a read
        bus_if.a_req = 1'b1; bus_if.a_addr = 15'h0010;
        #1;
        check("t6_gnt", 32'(bus_if.a_gnt), 32'd1);
        @(negedge clk);
        bus_if.a_req = 1'b0;
        #1;
        check("t6_rb_before", 32'(bus_if.mem_rb), 32'd1);
        rst_n = 1'b0;
        #1;
        check("t6_rb_rst", 32'(bus_if.mem_rb),   32'd0);
        check("t6_rv_rst", 32'(bus_if.a_rvalid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); #1;
            check("t6_no_stale_rv", 32'(bus_if.a_rvalid), 32'd0);
            check("t6_no_stale_rb", 32'(bus_if.mem_rb),   32'd0);
        end
        bus_if.a_req = 1'b1; bus_if.a_addr = 15'h0010;
        #1;
        check("t6_regnt", 32'(bus_if.a_gnt), 32'd1);
        @(negedge clk);
        bus_if.a_req = 1'b0;
        @(negedge clk); #1;
        check("t6_rdata", 32'(bus_if.a_rdata), 32'h1234);

        check("never_both_strobes", 32'(both_cnt), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
